// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants, state encoding and word-select helper for the I2S transmitter
package i2s_pkg;

    localparam int MODE_I2S = 0;
    localparam int MODE_LJ  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2s_state_e;

    // I2S raises word select one bit clock ahead of the right-channel data
    function automatic logic lrclk_level(input int p, input int word, input int mode);
        if (mode == MODE_LJ) begin
            return p >= word;
        end
        return (p >= word - 1) && (p <= 2 * word - 2);
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// rtl/i2s_sample_fifo.sv - synchronous stereo sample FIFO with full/empty flags and occupancy
module i2s_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/i2s_tx_master.sv
// rtl/i2s_tx_master.sv - I2S / left-justified transmit master with divided bit clock and sample FIFO
module i2s_tx_master
    import i2s_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int WORD    = 32,
    parameter int CLKDIV  = 4,
    parameter int MODE    = 0,
    parameter int DEPTH   = 2
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITSIZE-1:0] left_chan,
    input  logic [BITSIZE-1:0] right_chan,
    output logic               bclk,
    output logic               lrclk,
    output logic               sdata,
    output logic               underrun
);

    localparam int SRW = 2 * WORD;
    localparam int PW  = $clog2(SRW);
    localparam int DW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    i2s_state_e     state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    logic [PW-1:0]  p_q, p_d;
    logic [SRW-1:0] sr_q, sr_d;
    logic           bclk_q, bclk_d;
    logic           lrclk_q, lrclk_d;
    logic           sdata_q, sdata_d;
    logic           underrun_q, underrun_d;
    logic           in_ready_q, in_ready_d;
    logic           first_q, first_d;

    logic                   push;
    logic                   pop;
    logic [2*BITSIZE-1:0]   fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [SRW-1:0]         load_word;

    assign push = in_valid && in_ready_q;

    i2s_sample_fifo #(
        .WIDTH (2 * BITSIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (sclk),
        .rst_i     (rst),
        .push_i    (push),
        .wr_data_i ({left_chan, right_chan}),
        .pop_i     (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Each channel is MSB-aligned in its slot and zero padded below
    assign load_word = (SRW'(fifo_rd_data[2*BITSIZE-1:BITSIZE]) << (SRW - BITSIZE))
                     | (SRW'(fifo_rd_data[BITSIZE-1:0]) << (WORD - BITSIZE));

    assign in_ready_d = fifo_full ? pop
                                  : !((fifo_count == CW'(DEPTH - 1)) && push && !pop);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        p_d        = p_q;
        sr_d       = sr_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        first_d    = first_q;
        underrun_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                div_d   = '0;
                p_d     = '0;
                sr_d    = '0;
                bclk_d  = 1'b0;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
                if (enable) begin
                    state_d = ST_RUN;
                    first_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (div_q != DW'(CLKDIV - 1)) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d  = '0;
                    bclk_d = !bclk_q;
                    if (bclk_q) begin
                        if (first_q || p_q == PW'(SRW - 1)) begin
                            if (!enable) begin
                                state_d = ST_IDLE;
                                lrclk_d = 1'b0;
                                sdata_d = 1'b0;
                            end else begin
                                first_d    = 1'b0;
                                p_d        = '0;
                                pop        = !fifo_empty;
                                underrun_d = fifo_empty;
                                sr_d       = fifo_empty ? '0 : load_word;
                            end
                        end else begin
                            p_d  = p_q + PW'(1);
                            sr_d = sr_q << 1;
                        end
                        // I2S drives the bit that was at the head before this shift
                        if (state_d == ST_RUN) begin
                            lrclk_d = lrclk_level(int'(p_d), WORD, MODE);
                            sdata_d = (MODE == MODE_LJ) ? sr_d[SRW-1] : sr_q[SRW-1];
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            p_q        <= '0;
            sr_q       <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            in_ready_q <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            p_q        <= p_d;
            sr_q       <= sr_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            in_ready_q <= in_ready_d;
            first_q    <= first_d;
        end
    end

    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;
    assign in_ready = in_ready_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// tb/tb_i2s_tx_master.sv - scoreboard bench driving an I2S and a left-justified instance in lockstep
module tb_i2s_tx_master;

    localparam int BITSIZE = 16;
    localparam int WORD    = 32;
    localparam int CLKDIV  = 2;
    localparam int DEPTH   = 2;
    localparam int NBIT    = 2 * WORD;
    localparam int FRAME   = 4 * WORD * CLKDIV;
    localparam logic [63:0] LR_LJ  = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] LR_I2S = 64'h0000_0001_FFFF_FFFE;

    logic sclk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic in_valid = 1'b0;
    logic [BITSIZE-1:0] left_chan = '0;
    logic [BITSIZE-1:0] right_chan = '0;
    logic rdy_lj, bclk_lj, lr_lj, sd_lj, ur_lj;
    logic rdy_i2s, bclk_i2s, lr_i2s, sd_i2s, ur_i2s;

    i2s_tx_master #(.BITSIZE(BITSIZE), .WORD(WORD), .CLKDIV(CLKDIV), .MODE(1), .DEPTH(DEPTH)) dut_lj (
        .sclk(sclk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(rdy_lj),
        .left_chan(left_chan), .right_chan(right_chan),
        .bclk(bclk_lj), .lrclk(lr_lj), .sdata(sd_lj), .underrun(ur_lj)
    );

    i2s_tx_master #(.BITSIZE(BITSIZE), .WORD(WORD), .CLKDIV(CLKDIV), .MODE(0), .DEPTH(DEPTH)) dut_i2s (
        .sclk(sclk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(rdy_i2s),
        .left_chan(left_chan), .right_chan(right_chan),
        .bclk(bclk_i2s), .lrclk(lr_i2s), .sdata(sd_i2s), .underrun(ur_i2s)
    );

    always #5 sclk = ~sclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [31:0] s);
        return {s[31:16], 16'h0000, s[15:0], 16'h0000};
    endfunction

    // reference model state, written only by the monitor
    logic [31:0] mq[$];
    int          mdiv = 0;
    int          mp = 0;
    int          cyc = 0;
    int          last_start = -1;
    bit          midle = 1'b1;
    bit          mfirst = 1'b0;
    bit          mbclk = 1'b0;
    bit          mprev0 = 1'b0;
    bit          exp_ur = 1'b0;
    bit          exp_rdy = 1'b0;
    bit          m_push, m_rise, m_fall;
    logic [63:0] cur_f = '0;
    logic [63:0] cap_lj = '0, cap_i2s = '0, clr_lj = '0, clr_i2s = '0;

    initial begin
        forever begin
            @(posedge sclk);
            #1;
            cyc++;
            if (rst) begin
                midle = 1'b1; mfirst = 1'b0; mdiv = 0; mbclk = 1'b0; mp = 0;
                mq.delete(); exp_rdy = 1'b0; last_start = -1;
                chk("rst_outs", 64'({rdy_lj, rdy_i2s, bclk_lj, bclk_i2s, lr_lj, lr_i2s,
                                     sd_lj, sd_i2s, ur_lj, ur_i2s}), 64'd0);
            end else begin
                m_push = in_valid && exp_rdy;
                m_rise = 1'b0; m_fall = 1'b0; exp_ur = 1'b0;
                if (midle) begin
                    if (enable) begin
                        midle = 1'b0; mfirst = 1'b1; mdiv = 0; mbclk = 1'b0; mp = 0; last_start = -1;
                    end
                end else begin
                    if (mdiv == CLKDIV - 1) begin
                        mdiv = 0; m_rise = !mbclk; m_fall = mbclk; mbclk = !mbclk;
                    end else begin
                        mdiv++;
                    end
                    if (m_rise) begin
                        cap_lj[NBIT-1-mp]  = sd_lj;
                        cap_i2s[NBIT-1-mp] = sd_i2s;
                        clr_lj[NBIT-1-mp]  = lr_lj;
                        clr_i2s[NBIT-1-mp] = lr_i2s;
                        if (mp == NBIT - 1 && !mfirst) begin
                            chk("lj_frame", cap_lj, cur_f);
                            chk("i2s_frame", cap_i2s, {mprev0, cur_f[63:1]});
                            chk("lj_lrclk", clr_lj, LR_LJ);
                            chk("i2s_lrclk", clr_i2s, LR_I2S);
                        end
                    end
                    if (m_fall) begin
                        if (mfirst || mp == NBIT - 1) begin
                            if (!enable) begin
                                midle = 1'b1; mbclk = 1'b0;
                            end else begin
                                mprev0 = mfirst ? 1'b0 : cur_f[0];
                                if (last_start >= 0) chk("frame_period", 64'(cyc - last_start), 64'(FRAME));
                                last_start = cyc; mfirst = 1'b0; mp = 0;
                                if (mq.size() > 0) begin
                                    cur_f = pack(mq.pop_front());
                                end else begin
                                    cur_f = '0; exp_ur = 1'b1;
                                end
                            end
                        end else begin
                            mp++;
                        end
                    end
                end
                if (m_push) mq.push_back({left_chan, right_chan});
                exp_rdy = (mq.size() < DEPTH);
                chk("bclk", 64'({bclk_lj, bclk_i2s}), 64'({mbclk, mbclk}));
                chk("underrun", 64'({ur_lj, ur_i2s}), 64'({exp_ur, exp_ur}));
                chk("in_ready", 64'({rdy_lj, rdy_i2s}), 64'({exp_rdy, exp_rdy}));
                if (midle) chk("idle_outs", 64'({lr_lj, lr_i2s, sd_lj, sd_i2s}), 64'd0);
            end
        end
    end

    // call at a falling edge; returns at the falling edge after acceptance
    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        bit accepted = 1'b0;
        in_valid = 1'b1; left_chan = l; right_chan = r;
        for (int i = 0; i < 2000 && !accepted; i++) begin
            accepted = rdy_lj;
            @(negedge sclk);
        end
        in_valid = 1'b0;
        if (!accepted) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_p(input int target);
        bit hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge sclk);
            hit = !midle && !mfirst && (mp == target);
        end
        if (!hit) chk("wait_p_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge sclk);
        rst = 1'b0;
        @(negedge sclk);

        // known pattern, then three frames with nothing queued
        push_frame(16'hA55A, 16'h0F0F);
        enable = 1'b1;
        repeat (FRAME * 4) @(negedge sclk);

        for (int k = 0; k < 5; k++) push_frame(16'($urandom), 16'($urandom));

        // stop mid-frame with samples still queued; they must survive idle
        push_frame(16'h1234, 16'h5678);
        push_frame(16'h9ABC, 16'hDEF0);
        wait_p(10);
        enable = 1'b0;
        repeat (FRAME + 64) @(negedge sclk);
        enable = 1'b1;
        repeat (FRAME * 4) @(negedge sclk);
        wait_p(10);
        enable = 1'b0;
        repeat (FRAME + 64) @(negedge sclk);

        // fill while idle: third frame is held off until a pop
        push_frame(16'h8001, 16'h7FFE);
        push_frame(16'hFFFF, 16'h0001);
        chk("full_ready", 64'(rdy_lj), 64'd0);
        in_valid = 1'b1; left_chan = 16'hC3C3; right_chan = 16'h3C3C;
        repeat (20) @(negedge sclk);
        chk("held_ready", 64'(rdy_lj), 64'd0);
        enable = 1'b1;
        push_frame(16'hC3C3, 16'h3C3C);
        repeat (FRAME * 4) @(negedge sclk);

        // reset mid-frame with data queued, then restart
        push_frame(16'hBEEF, 16'hCAFE);
        wait_p(20);
        rst = 1'b1;
        @(negedge sclk);
        rst = 1'b0;
        @(negedge sclk);
        push_frame(16'h5A5A, 16'hA5A5);
        repeat (FRAME * 3) @(negedge sclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog expired after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2s_tx_master.md
I2S_TX_MASTER -- requirements
Module: i2s_tx_master

Interface
REQ-001 The block SHALL have parameter BITSIZE, default 16, meaning sample width per channel (1..WORD).
REQ-002 The block SHALL have parameter WORD, default 32, meaning slot width in bit clocks per channel (16..32).
REQ-003 The block SHALL have parameter CLKDIV, default 4, meaning sclk cycles per bclk half-period (>=1).
REQ-004 The block SHALL have parameter MODE, default 0, meaning frame format: 0 = I2S (one-bit delay), 1 = left-justified.
REQ-005 The block SHALL have parameter DEPTH, default 2, meaning sample-FIFO depth in stereo frames (power of 2, >=2).
REQ-006 The block SHALL have one clock and a synchronous, active-high reset, with ports: sclk  in  1  system clock, sole clock; rst  in  1  synchronous active-high reset.
REQ-007 The block SHALL have ports: enable  in  1  run request; in_valid  in  1  frame offered; in_ready  out  1  FIFO not full.
REQ-008 The block SHALL have ports: left_chan  in  BITSIZE  left sample; right_chan  in  BITSIZE  right sample.
REQ-009 The block SHALL have ports: bclk  out  1  bit clock; lrclk  out  1  word select; sdata  out  1  serial data; underrun  out  1  one-cycle pulse.

Function
REQ-010 The block SHALL register every output in the sclk domain; bclk SHALL be a divided sclk, never a gated clock.
REQ-011 The block SHALL run a divider 0..CLKDIV-1 in RUN; at terminal count bclk toggles, giving a rise event (0->1) or fall event (1->0).
REQ-012 The block SHALL keep a slot counter p, 0..2*WORD-1, advancing on each fall event and wrapping from 2*WORD-1 to 0.
REQ-013 The block SHALL update sdata and lrclk only on fall events, so the receiver samples on the bclk rise.
REQ-014 For MODE=1, lrclk SHALL be 1 for p in WORD..2*WORD-1, else 0; for MODE=0, lrclk SHALL be 1 for p in WORD-1..2*WORD-2, else 0 (leading data by one bclk).
REQ-015 At the fall event entering p=0 (frame start), the block SHALL load a 2*WORD shift register with {left, WORD-BITSIZE zeros, right, WORD-BITSIZE zeros} popped from the FIFO head.
REQ-016 For MODE=0, data SHALL be delayed one bclk: the left MSB is driven at p=1 and the last right bit at p=0 of the next frame.
REQ-017 For MODE=1, the left MSB SHALL be driven at p=0.
REQ-018 Otherwise, each fall event SHALL shift the register one bit toward the MSB, and sdata SHALL equal the bit selected for the mode.
REQ-019 If the FIFO is empty at frame start, the block SHALL load all-zero data, pop nothing and pulse underrun high for exactly one sclk cycle.
REQ-020 in_ready SHALL equal !full; a push SHALL occur on in_valid & in_ready; a push and a pop in the same cycle SHALL both take effect.
REQ-021 A push in the same cycle as a frame-start load on an empty FIFO SHALL NOT bypass; that load underruns and the sample goes out next frame.
REQ-022 The block SHALL have states IDLE and RUN; IDLE SHALL hold bclk=0, lrclk=0, sdata=0 and a cleared divider.
REQ-023 IDLE->RUN SHALL occur on the cycle enable=1; the first rise event SHALL come CLKDIV cycles later, and the first fall event SHALL start frame p=0.
REQ-024 Deasserting enable mid-frame SHALL let the frame complete; RUN->IDLE SHALL occur at the fall event that would wrap p to 0, with no pop and no underrun.
REQ-025 The frame period SHALL be 4*WORD*CLKDIV sclk cycles.

Reset
REQ-026 rst SHALL force IDLE, empty the FIFO and clear the shift register, p and the divider.
REQ-027 rst SHALL drive bclk=0, lrclk=0, sdata=0 and underrun=0; in_ready SHALL be 0 during reset and 1 on the cycle after rst falls.
REQ-028 rst asserted mid-frame SHALL abort the frame immediately, with no completion.

Structure
REQ-029 Package i2s_pkg SHALL hold the MODE_I2S=0 and MODE_LJ=1 constants and the state encoding.
REQ-030 Sub-module i2s_sample_fifo (synchronous, width 2*BITSIZE, DEPTH entries, full/empty flags) SHALL hold the samples.
REQ-031 Divider, slot counter, shift register and FSM SHALL stay in the top level.

Verification (BITSIZE=16, WORD=32, CLKDIV=2 unless stated)
REQ-032 MODE=1, push L=0xA55A, R=0x0F0F, enable=1 -> 64 bclk bits: 1010010101011010, 16 zeros, 0000111100001111, 16 zeros; lrclk falls with p=0.
REQ-033 MODE=0, same data -> first bit is 0 and the left MSB appears one bclk later; lrclk leads the data by one bclk.
REQ-034 No push, enable=1 -> sdata all zero, one underrun pulse per 256-cycle frame.
REQ-035 DEPTH=2, enable=0, push three frames back-to-back -> in_ready low after the second push, and the third frame stays held until a pop.
REQ-036 Drop enable at p=10 -> the frame runs to p=63, then IDLE with bclk=0 and FIFO contents unchanged.
REQ-037 rst at p=20 -> next cycle all outputs are 0 and the FIFO is empty; enable restarts the frame at p=0.
